// File: rtl/axi_lite_llink_pkg.sv
// Shared constants and packed-word width helpers for the AXI-Lite logic-link adapter.
package axi_lite_llink_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Packed W word is {wstrb, wdata}; packed R word is {rresp, rdata}.
  function automatic int w_width(input int dw);
    return dw + dw / 8;
  endfunction

  function automatic int r_width(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/axi_lite_skid_buf.sv
// Two-entry registered skid buffer: strict FIFO order, registered upstream ready,
// no combinational path from downstream ready to upstream ready.
module axi_lite_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  logic [1:0]       r_cnt;
  logic             r_rdy;
  logic [WIDTH-1:0] r_d0;
  logic [WIDTH-1:0] r_d1;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_cnt_nxt;

  assign w_push  = i_valid && r_rdy;
  assign w_pop   = (r_cnt != 2'd0) && i_ready;
  assign o_ready = r_rdy;
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_d0;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + 2'd1;
    else if (w_pop && !w_push) w_cnt_nxt = r_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_rdy <= 1'b1;
      r_d0  <= '0;
      r_d1  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
      // r_d0 is always the head; r_d1 only holds the second entry.
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_d0 <= i_data;
          else               r_d1 <= i_data;
        end
        2'b01: r_d0 <= r_d1;
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_d0 <= i_data;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axi_lite_master_llink_buf.sv
// AXI4-Lite master-side logic-link adapter: five skid-buffered channels plus
// outstanding read/write counters. Define AXI_LITE_OUT_LIMIT_EN to throttle AR/AW at MAX_OUT.
module axi_lite_master_llink_buf
  import axi_lite_llink_pkg::*;
#(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                                 clk_wr,
  input  logic                                 rst_wr_n,
  input  logic [AWIDTH-1:0]                    user_araddr,
  input  logic                                 user_arvalid,
  output logic                                 user_arready,
  input  logic [AWIDTH-1:0]                    user_awaddr,
  input  logic                                 user_awvalid,
  output logic                                 user_awready,
  input  logic [DWIDTH-1:0]                    user_wdata,
  input  logic [DWIDTH/8-1:0]                  user_wstrb,
  input  logic                                 user_wvalid,
  output logic                                 user_wready,
  output logic [DWIDTH-1:0]                    user_rdata,
  output logic [1:0]                           user_rresp,
  output logic                                 user_rvalid,
  input  logic                                 user_rready,
  output logic [1:0]                           user_bresp,
  output logic                                 user_bvalid,
  input  logic                                 user_bready,
  output logic                                 user_ar_lite_valid,
  output logic [AWIDTH-1:0]                    txfifo_ar_lite_data,
  input  logic                                 user_ar_lite_ready,
  output logic                                 user_aw_lite_valid,
  output logic [AWIDTH-1:0]                    txfifo_aw_lite_data,
  input  logic                                 user_aw_lite_ready,
  output logic                                 user_w_lite_valid,
  output logic [w_width(DWIDTH)-1:0]           txfifo_w_lite_data,
  input  logic                                 user_w_lite_ready,
  input  logic                                 user_r_lite_valid,
  input  logic [r_width(DWIDTH)-1:0]           rxfifo_r_lite_data,
  output logic                                 user_r_lite_ready,
  input  logic                                 user_b_lite_valid,
  input  logic [1:0]                           rxfifo_b_lite_data,
  output logic                                 user_b_lite_ready,
  output logic [$clog2(MAX_OUT+1)-1:0]         rd_out_cnt,
  output logic [$clog2(MAX_OUT+1)-1:0]         wr_out_cnt,
  output logic                                 cnt_err
);

  localparam int             CW    = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0]  C_MAX = CW'(MAX_OUT);

  logic [CW-1:0]             r_rd_cnt;
  logic [CW-1:0]             r_wr_cnt;
  logic                      r_cnt_err;
  logic                      w_ar_rdy;
  logic                      w_aw_rdy;
  logic                      w_rd_ok;
  logic                      w_wr_ok;
  logic                      w_rd_inc;
  logic                      w_rd_dec;
  logic                      w_wr_inc;
  logic                      w_wr_dec;
  logic [r_width(DWIDTH)-1:0] w_r_word;

`ifdef AXI_LITE_OUT_LIMIT_EN
  assign w_rd_ok = (r_rd_cnt < C_MAX);
  assign w_wr_ok = (r_wr_cnt < C_MAX);
`else
  assign w_rd_ok = 1'b1;
  assign w_wr_ok = 1'b1;
`endif

  // Gating is folded into the buffer's valid so a blocked request is never captured.
  assign user_arready = w_ar_rdy && w_rd_ok;
  assign user_awready = w_aw_rdy && w_wr_ok;

  axi_lite_skid_buf #(.WIDTH(AWIDTH)) u_ar_buf (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .i_valid(user_arvalid && w_rd_ok), .i_data(user_araddr), .o_ready(w_ar_rdy),
    .o_valid(user_ar_lite_valid), .o_data(txfifo_ar_lite_data), .i_ready(user_ar_lite_ready)
  );

  axi_lite_skid_buf #(.WIDTH(AWIDTH)) u_aw_buf (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .i_valid(user_awvalid && w_wr_ok), .i_data(user_awaddr), .o_ready(w_aw_rdy),
    .o_valid(user_aw_lite_valid), .o_data(txfifo_aw_lite_data), .i_ready(user_aw_lite_ready)
  );

  axi_lite_skid_buf #(.WIDTH(w_width(DWIDTH))) u_w_buf (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .i_valid(user_wvalid), .i_data({user_wstrb, user_wdata}), .o_ready(user_wready),
    .o_valid(user_w_lite_valid), .o_data(txfifo_w_lite_data), .i_ready(user_w_lite_ready)
  );

  axi_lite_skid_buf #(.WIDTH(r_width(DWIDTH))) u_r_buf (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .i_valid(user_r_lite_valid), .i_data(rxfifo_r_lite_data), .o_ready(user_r_lite_ready),
    .o_valid(user_rvalid), .o_data(w_r_word), .i_ready(user_rready)
  );

  axi_lite_skid_buf #(.WIDTH(2)) u_b_buf (
    .clk(clk_wr), .rst_n(rst_wr_n),
    .i_valid(user_b_lite_valid), .i_data(rxfifo_b_lite_data), .o_ready(user_b_lite_ready),
    .o_valid(user_bvalid), .o_data(user_bresp), .i_ready(user_bready)
  );

  assign {user_rresp, user_rdata} = w_r_word;

  assign w_rd_inc = user_arvalid && user_arready;
  assign w_rd_dec = user_rvalid && user_rready;
  assign w_wr_inc = user_awvalid && user_awready;
  assign w_wr_dec = user_bvalid && user_bready;

  // Counters saturate at MAX_OUT and hold at zero; an underflow attempt latches cnt_err.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_cnt_err <= 1'b0;
    end else begin
      if (w_rd_inc && !w_rd_dec) begin
        if (r_rd_cnt != C_MAX) r_rd_cnt <= r_rd_cnt + 1'b1;
      end else if (w_rd_dec && !w_rd_inc) begin
        if (r_rd_cnt == '0) r_cnt_err <= 1'b1;
        else                r_rd_cnt  <= r_rd_cnt - 1'b1;
      end
      if (w_wr_inc && !w_wr_dec) begin
        if (r_wr_cnt != C_MAX) r_wr_cnt <= r_wr_cnt + 1'b1;
      end else if (w_wr_dec && !w_wr_inc) begin
        if (r_wr_cnt == '0) r_cnt_err <= 1'b1;
        else                r_wr_cnt  <= r_wr_cnt - 1'b1;
      end
    end
  end

  assign rd_out_cnt = r_rd_cnt;
  assign wr_out_cnt = r_wr_cnt;
  assign cnt_err    = r_cnt_err;

endmodule

// File: tb/tb_axi_lite_master_llink_buf.sv
// Directed self-checking bench for axi_lite_master_llink_buf (AWIDTH=DWIDTH=32, MAX_OUT=4).
module tb_axi_lite_master_llink_buf;
  import axi_lite_llink_pkg::*;

`ifdef AXI_LITE_OUT_LIMIT_EN
  localparam logic LIMIT = 1'b1;
`else
  localparam logic LIMIT = 1'b0;
`endif

  logic        clk_wr = 1'b0;
  logic        rst_wr_n = 1'b0;
  logic [31:0] user_araddr, user_awaddr, user_wdata, user_rdata;
  logic        user_arvalid, user_arready, user_awvalid, user_awready;
  logic [3:0]  user_wstrb;
  logic        user_wvalid, user_wready;
  logic [1:0]  user_rresp, user_bresp;
  logic        user_rvalid, user_rready, user_bvalid, user_bready;
  logic        user_ar_lite_valid, user_ar_lite_ready;
  logic [31:0] txfifo_ar_lite_data, txfifo_aw_lite_data;
  logic        user_aw_lite_valid, user_aw_lite_ready;
  logic        user_w_lite_valid, user_w_lite_ready;
  logic [35:0] txfifo_w_lite_data;
  logic        user_r_lite_valid, user_r_lite_ready;
  logic [33:0] rxfifo_r_lite_data;
  logic        user_b_lite_valid, user_b_lite_ready;
  logic [1:0]  rxfifo_b_lite_data;
  logic [2:0]  rd_out_cnt, wr_out_cnt;
  logic        cnt_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [35:0] exp_q[$];

  always #5 clk_wr = ~clk_wr;

  axi_lite_master_llink_buf #(.AWIDTH(32), .DWIDTH(32), .MAX_OUT(4)) dut (
    .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
    .user_araddr(user_araddr), .user_arvalid(user_arvalid), .user_arready(user_arready),
    .user_awaddr(user_awaddr), .user_awvalid(user_awvalid), .user_awready(user_awready),
    .user_wdata(user_wdata), .user_wstrb(user_wstrb), .user_wvalid(user_wvalid),
    .user_wready(user_wready),
    .user_rdata(user_rdata), .user_rresp(user_rresp), .user_rvalid(user_rvalid),
    .user_rready(user_rready),
    .user_bresp(user_bresp), .user_bvalid(user_bvalid), .user_bready(user_bready),
    .user_ar_lite_valid(user_ar_lite_valid), .txfifo_ar_lite_data(txfifo_ar_lite_data),
    .user_ar_lite_ready(user_ar_lite_ready),
    .user_aw_lite_valid(user_aw_lite_valid), .txfifo_aw_lite_data(txfifo_aw_lite_data),
    .user_aw_lite_ready(user_aw_lite_ready),
    .user_w_lite_valid(user_w_lite_valid), .txfifo_w_lite_data(txfifo_w_lite_data),
    .user_w_lite_ready(user_w_lite_ready),
    .user_r_lite_valid(user_r_lite_valid), .rxfifo_r_lite_data(rxfifo_r_lite_data),
    .user_r_lite_ready(user_r_lite_ready),
    .user_b_lite_valid(user_b_lite_valid), .rxfifo_b_lite_data(rxfifo_b_lite_data),
    .user_b_lite_ready(user_b_lite_ready),
    .rd_out_cnt(rd_out_cnt), .wr_out_cnt(wr_out_cnt), .cnt_err(cnt_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_wr);
    #1;
  endtask

  task automatic push_r(input logic [1:0] resp, input logic [31:0] data);
    rxfifo_r_lite_data = {resp, data};
    user_r_lite_valid  = 1'b1;
    tick();
    user_r_lite_valid  = 1'b0;
    tick();
  endtask

  task automatic push_b(input logic [1:0] resp);
    rxfifo_b_lite_data = resp;
    user_b_lite_valid  = 1'b1;
    tick();
    user_b_lite_valid  = 1'b0;
    tick();
  endtask

  initial begin
    int          sent;
    int          rcvd;
    logic [35:0] exp_w;

    user_araddr = '0; user_arvalid = 1'b0; user_awaddr = '0; user_awvalid = 1'b0;
    user_wdata = '0; user_wstrb = '0; user_wvalid = 1'b0;
    user_rready = 1'b1; user_bready = 1'b1;
    user_ar_lite_ready = 1'b1; user_aw_lite_ready = 1'b1; user_w_lite_ready = 1'b1;
    user_r_lite_valid = 1'b0; rxfifo_r_lite_data = '0;
    user_b_lite_valid = 1'b0; rxfifo_b_lite_data = '0;

    // Reset values
    repeat (3) @(posedge clk_wr);
    #1;
    check("rst_ar_lite_valid", user_ar_lite_valid, 0);
    check("rst_w_lite_valid", user_w_lite_valid, 0);
    check("rst_rvalid", user_rvalid, 0);
    check("rst_bvalid", user_bvalid, 0);
    check("rst_arready", user_arready, 1);
    check("rst_wready", user_wready, 1);
    check("rst_r_lite_ready", user_r_lite_ready, 1);
    check("rst_ar_data", txfifo_ar_lite_data, 0);
    check("rst_rd_cnt", rd_out_cnt, 0);
    check("rst_cnt_err", cnt_err, 0);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    tick();

    // Single AR, one-cycle latency to the TX FIFO side
    user_araddr  = 32'h1000_0040;
    user_arvalid = 1'b1;
    check("ar1_arready", user_arready, 1);
    tick();
    user_arvalid = 1'b0;
    check("ar1_lite_valid", user_ar_lite_valid, 1);
    check("ar1_lite_data", txfifo_ar_lite_data, 32'h1000_0040);
    check("ar1_rd_cnt", rd_out_cnt, 1);
    tick();
    check("ar1_drained", user_ar_lite_valid, 0);

    // R unpack {rresp, rdata}
    rxfifo_r_lite_data = {SLVERR, 32'hDEAD_BEEF};
    user_r_lite_valid  = 1'b1;
    tick();
    user_r_lite_valid  = 1'b0;
    check("r1_rvalid", user_rvalid, 1);
    check("r1_rdata", user_rdata, 32'hDEAD_BEEF);
    check("r1_rresp", user_rresp, 2'b10);
    tick();
    check("r1_rd_cnt", rd_out_cnt, 0);
    check("r1_rvalid_done", user_rvalid, 0);

    // W stream with downstream ready toggling
    sent = 0;
    rcvd = 0;
    for (int c = 0; c < 40 && rcvd < 4; c++) begin
      user_w_lite_ready = (c % 2 == 0);
      user_wvalid = (sent < 4);
      user_wdata  = 32'hA5A5_0000 + 32'(sent);
      user_wstrb  = 4'hF;
      if (user_wvalid && user_wready) begin
        exp_q.push_back({4'hF, user_wdata});
        sent++;
      end
      if (user_w_lite_valid && user_w_lite_ready) begin
        if (rcvd == 0) check("w_first", txfifo_w_lite_data, 36'hF_A5A5_0000);
        if (exp_q.size() == 0) begin
          check("w_extra", 1, 0);
        end else begin
          exp_w = exp_q.pop_front();
          check("w_word", txfifo_w_lite_data, exp_w);
        end
        rcvd++;
      end
      tick();
    end
    user_wvalid = 1'b0;
    user_w_lite_ready = 1'b1;
    check("w_rcvd", rcvd, 4);
    check("w_q_empty", exp_q.size(), 0);
    tick();
    check("w_no_dup", user_w_lite_valid, 0);

    // Outstanding read limit / saturation at MAX_OUT
    for (int i = 0; i < 4; i++) begin
      user_araddr  = 32'h2000_0000 + 32'(i * 4);
      user_arvalid = 1'b1;
      check("lim_arready_open", user_arready, 1);
      tick();
    end
    user_araddr = 32'h2000_0010;
    check("lim_cnt4", rd_out_cnt, 4);
    check("lim_arready_4", user_arready, !LIMIT);
    tick();
    user_arvalid = 1'b0;
    check("lim_cnt_hold", rd_out_cnt, 4);
    check("lim_arready_5", user_arready, !LIMIT);
    rxfifo_r_lite_data = {OKAY, 32'h1111_0000};
    user_r_lite_valid  = 1'b1;
    tick();
    user_r_lite_valid  = 1'b0;
    tick();
    check("lim_cnt3", rd_out_cnt, 3);
    check("lim_arready_back", user_arready, 1);
    for (int i = 0; i < 3; i++) push_r(OKAY, 32'h1111_0001 + 32'(i));
    check("lim_cnt0", rd_out_cnt, 0);
    check("lim_no_err", cnt_err, 0);

    // AW and B handshake in the same cycle
    user_awaddr  = 32'h3000_0000;
    user_awvalid = 1'b1;
    tick();
    tick();
    user_awvalid = 1'b0;
    check("aw_cnt2", wr_out_cnt, 2);
    user_bready = 1'b0;
    rxfifo_b_lite_data = DECERR;
    user_b_lite_valid  = 1'b1;
    tick();
    user_b_lite_valid  = 1'b0;
    check("b_bvalid", user_bvalid, 1);
    check("b_bresp", user_bresp, 2'b11);
    tick();
    check("b_bvalid_hold", user_bvalid, 1);
    user_awvalid = 1'b1;
    user_bready  = 1'b1;
    tick();
    user_awvalid = 1'b0;
    check("awb_cnt_same", wr_out_cnt, 2);
    check("awb_aw_lite", txfifo_aw_lite_data, 32'h3000_0000);
    push_b(OKAY);
    push_b(EXOKAY);
    check("b_cnt0", wr_out_cnt, 0);
    check("b_no_err", cnt_err, 0);

    // Response with counter at zero
    push_r(OKAY, 32'h5555_AAAA);
    check("under_rd_cnt", rd_out_cnt, 0);
    check("under_err", cnt_err, 1);
    repeat (3) tick();
    check("under_err_sticky", cnt_err, 1);

    // Reset with two buffered R words
    user_arvalid = 1'b1;
    tick();
    user_arvalid = 1'b0;
    user_rready  = 1'b0;
    rxfifo_r_lite_data = {OKAY, 32'h7777_0001};
    user_r_lite_valid  = 1'b1;
    tick();
    rxfifo_r_lite_data = {OKAY, 32'h7777_0002};
    tick();
    user_r_lite_valid  = 1'b0;
    check("pre_rst_rvalid", user_rvalid, 1);
    check("pre_rst_r_full", user_r_lite_ready, 0);
    check("pre_rst_rd_cnt", rd_out_cnt, 1);
    #2;
    rst_wr_n = 1'b0;
    #1;
    check("mid_rst_rvalid", user_rvalid, 0);
    check("mid_rst_ar_valid", user_ar_lite_valid, 0);
    check("mid_rst_r_ready", user_r_lite_ready, 1);
    check("mid_rst_rd_cnt", rd_out_cnt, 0);
    check("mid_rst_err", cnt_err, 0);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    user_rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_r", user_rvalid, 0);
    end
    check("post_rst_rd_cnt", rd_out_cnt, 0);
    check("post_rst_wr_cnt", wr_out_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master_llink_buf.md
# axi_lite_master_llink_buf

Parametrised AXI4-Lite master-side logic-link adapter with a two-entry registered skid buffer on every channel and outstanding-transaction tracking. It converts the five user AXI-Lite channels (AR, AW, W, R, B) to and from the packed logic-link FIFO words, with width set by parameters. It can also throttle new read and write address requests once a configurable outstanding limit is reached. It sits between the user AXI-Lite master and the AIB logic-link TX/RX FIFOs.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width; multiple of 8; strobe width SW = DWIDTH/8
- MAX_OUT, 4, outstanding reads and outstanding writes allowed, each; range 1..255
- clk_wr  in  1  single clock; all logic rising-edge
- rst_wr_n  in  1  reset, asynchronous and active-low
- user_araddr/arvalid/arready  in/in/out  AWIDTH/1/1  user AR channel
- user_awaddr/awvalid/awready  in/in/out  AWIDTH/1/1  user AW channel
- user_wdata/wstrb/wvalid/wready  in/in/in/out  DWIDTH/SW/1/1  user W channel
- user_rdata/rresp/rvalid/rready  out/out/out/in  DWIDTH/2/1/1  user R channel
- user_bresp/bvalid/bready  out/out/in  2/1/1  user B channel
- user_ar_lite_valid/txfifo_ar_lite_data/user_ar_lite_ready  out/out/in  1/AWIDTH/1
- user_aw_lite_valid/txfifo_aw_lite_data/user_aw_lite_ready  out/out/in  1/AWIDTH/1
- user_w_lite_valid/txfifo_w_lite_data/user_w_lite_ready  out/out/in  1/DWIDTH+SW/1; packed {wstrb, wdata}, wdata at bit 0
- user_r_lite_valid/rxfifo_r_lite_data/user_r_lite_ready  in/in/out  1/DWIDTH+2/1; packed {rresp, rdata}
- user_b_lite_valid/rxfifo_b_lite_data/user_b_lite_ready  in/in/out  1/2/1
- rd_out_cnt  out  $clog2(MAX_OUT+1)  current outstanding reads
- wr_out_cnt  out  $clog2(MAX_OUT+1)  current outstanding writes
- cnt_err  out  1  sticky; set when a response arrives while its counter is 0

## Operation
- Each of the five channels passes through one two-entry skid buffer. Entry count is 0..2.
  - Upstream ready = (count < 2), driven from a register.
  - Downstream valid = (count > 0). Order is strict FIFO.
- Packing and unpacking are pure bit placement; no field is altered.
- Read counter:
  - +1 on a user AR handshake (user_arvalid && user_arready).
  - −1 on a user R handshake (user_rvalid && user_rready).
  - Both in the same cycle: count unchanged.
- Write counter: +1 on a user AW handshake, −1 on a user B handshake; same simultaneous rule.
- Counter at 0 with a decrement event: count stays 0 and cnt_err sets. Only reset clears cnt_err.
- W data is never gated by the counters. W may precede AW.
- Reset (any time, including mid-burst):
  - All buffers empty and all valids low.
  - Upstream readies high after release.
  - Counters 0; cnt_err 0; in-flight buffered words discarded.

## Timing
- Reset values:
  - Every *valid output 0; user_arready, user_awready, user_wready, user_r_lite_ready, user_b_lite_ready all 1.
  - All data outputs 0; rd_out_cnt, wr_out_cnt, cnt_err all 0.
- Latency: a word accepted at edge N is presented downstream from cycle N+1, in both directions.
- Throughput is one word per cycle per channel with continuous ready. A ready deassertion costs no bubble; the second entry absorbs it.
- Downstream valid and data hold stable until accepted (AXI rule); no combinational path from downstream ready to upstream ready.
- Counters update on the edge of the handshake. The gated ready reflects the new count from the next cycle.

## Configuration
- AXI_LITE_OUT_LIMIT_EN
  - Defined:
    - user_arready = buffer ready && (rd_out_cnt < MAX_OUT).
    - user_awready = buffer ready && (wr_out_cnt < MAX_OUT).
  - Undefined: readies come from the buffers only. Counters and cnt_err still run (status only) and saturate at MAX_OUT rather than wrapping.

## Structure
- Package axi_lite_llink_pkg holds:
  - resp encoding constants OKAY/EXOKAY/SLVERR/DECERR = 2'b00/01/10/11.
  - packed-width functions (w = DWIDTH+DWIDTH/8, r = DWIDTH+2).
- Sub-module axi_lite_skid_buf, parameter WIDTH, instantiated five times. Counters and gating are in the top level.

## Test plan
- Reset, then AR addr 0x1000_0040 with tx ready=1 → user_ar_lite_valid=1 one cycle later with data 0x1000_0040; rd_out_cnt=1.
- W stream 0xA5A5_0000..+3 with wstrb 0xF, user_w_lite_ready toggling 1/0 → four words delivered in order with no loss or duplication, e.g. first word 0xF_A5A5_0000.
- With AXI_LITE_OUT_LIMIT_EN and MAX_OUT=4, issue 5 ARs with no R → user_arready=0 after the 4th handshake; after one R handshake it returns to 1 next cycle.
- AW handshake and B handshake in the same cycle with wr_out_cnt=2 → wr_out_cnt stays 2.
- Inject an R with rd_out_cnt=0 → rd_out_cnt stays 0 and cnt_err=1 until reset.
- Assert rst_wr_n=0 with two buffered R words → all valids 0 immediately; after release the R words are not delivered and the counters read 0.
